// File: rtl/dda_ctrl_pkg.sv
// rtl/dda_ctrl_pkg.sv - shared FSM type, config byte map and sample selector codes
package dda_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_EMIT,
    ST_STEP,
    ST_DONE
  } run_state_t;

  // Byte addresses in the config window; even = low byte, odd = high byte.
  localparam logic [3:0] CFG_ICX_LO   = 4'h0;
  localparam logic [3:0] CFG_ICX_HI   = 4'h1;
  localparam logic [3:0] CFG_ICY_LO   = 4'h2;
  localparam logic [3:0] CFG_ICY_HI   = 4'h3;
  localparam logic [3:0] CFG_ICZ_LO   = 4'h4;
  localparam logic [3:0] CFG_ICZ_HI   = 4'h5;
  localparam logic [3:0] CFG_SIGMA_LO = 4'h6;
  localparam logic [3:0] CFG_SIGMA_HI = 4'h7;
  localparam logic [3:0] CFG_BETA_LO  = 4'h8;
  localparam logic [3:0] CFG_BETA_HI  = 4'h9;
  localparam logic [3:0] CFG_RHO_LO   = 4'hA;
  localparam logic [3:0] CFG_RHO_HI   = 4'hB;
  localparam logic [3:0] CFG_DT_LO    = 4'hC;
  localparam logic [3:0] CFG_DT_HI    = 4'hD;
  localparam logic [3:0] CFG_STEPS_LO = 4'hE;
  localparam logic [3:0] CFG_STEPS_HI = 4'hF;

  // Word slots inside the register file (address bits 3:1).
  localparam logic [2:0] WORD_ICX   = 3'd0;
  localparam logic [2:0] WORD_ICY   = 3'd1;
  localparam logic [2:0] WORD_ICZ   = 3'd2;
  localparam logic [2:0] WORD_SIGMA = 3'd3;
  localparam logic [2:0] WORD_BETA  = 3'd4;
  localparam logic [2:0] WORD_RHO   = 3'd5;
  localparam logic [2:0] WORD_DT    = 3'd6;
  localparam logic [2:0] WORD_STEPS = 3'd7;

  // Sample stream word order.
  localparam logic [1:0] SEL_X = 2'd0;
  localparam logic [1:0] SEL_Y = 2'd1;
  localparam logic [1:0] SEL_Z = 2'd2;

endpackage

// File: rtl/dda_cfg_regs.sv
// rtl/dda_cfg_regs.sv - byte-writable configuration register file with write inhibit
module dda_cfg_regs
  import dda_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   addr,
  input  logic [7:0]   data,
  input  logic         inhibit,
  output logic [N-1:0] icx,
  output logic [N-1:0] icy,
  output logic [N-1:0] icz,
  output logic [N-1:0] sigma,
  output logic [N-1:0] beta,
  output logic [N-1:0] rho,
  output logic [N-1:0] dt,
  output logic [N-1:0] steps
);

  logic [N-1:0] word_q [8];

  // Byte write into the addressed word; the run inhibits writes so the
  // core sees constant parameters for the whole integration.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        word_q[i] <= '0;
      end
    end else if (we && !inhibit) begin
      if (addr[0]) begin
        word_q[addr[3:1]][15:8] <= data;
      end else begin
        word_q[addr[3:1]][7:0] <= data;
      end
    end
  end

  assign icx   = word_q[WORD_ICX];
  assign icy   = word_q[WORD_ICY];
  assign icz   = word_q[WORD_ICZ];
  assign sigma = word_q[WORD_SIGMA];
  assign beta  = word_q[WORD_BETA];
  assign rho   = word_q[WORD_RHO];
  assign dt    = word_q[WORD_DT];
  assign steps = word_q[WORD_STEPS];

endmodule

// File: rtl/dda_run_ctrl.sv
// rtl/dda_run_ctrl.sv - run sequencer driving the posit Lorenz DDA core and streaming samples
module dda_run_ctrl
  import dda_ctrl_pkg::*;
#(
  parameter int N      = 16,
  parameter int STEP_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [7:0]   cfg_data,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] icx,
  output logic [N-1:0] icy,
  output logic [N-1:0] icz,
  output logic [N-1:0] sigma,
  output logic [N-1:0] beta,
  output logic [N-1:0] rho,
  output logic [N-1:0] dt,
  output logic         dda_en,
  output logic         dda_rst,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_sel
);

  run_state_t        state;
  run_state_t        state_nxt;
  logic [N-1:0]      steps_w;
  logic [STEP_W-1:0] cnt;
  logic [1:0]        sel_q;
  logic              snap_pending;
  logic [N-1:0]      snap_x;
  logic [N-1:0]      snap_y;
  logic [N-1:0]      snap_z;

  dda_cfg_regs #(
    .N(N)
  ) u_cfg (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we),
    .addr   (cfg_addr),
    .data   (cfg_data),
    .inhibit(busy),
    .icx    (icx),
    .icy    (icy),
    .icz    (icz),
    .sigma  (sigma),
    .beta   (beta),
    .rho    (rho),
    .dt     (dt),
    .steps  (steps_w)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control outputs; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dda_en    = 1'b0;
    dda_rst   = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        busy      = 1'b1;
        dda_en    = 1'b1;
        dda_rst   = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && sel_q == SEL_Z) begin
          state_nxt = (cnt != '0) ? ST_STEP : ST_DONE;
        end
      end
      ST_STEP: begin
        busy      = 1'b1;
        dda_en    = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_DONE: begin
        done      = !abort;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // Remaining-step counter: loaded on start, decremented once per Euler step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_IDLE && start && !abort) begin
      cnt <= STEP_W'(steps_w);
    end else if (state == ST_STEP && cnt != '0) begin
      cnt <= cnt - STEP_W'(1);
    end
  end

  // Word selector: walks x, y, z on each accepted beat, parked at x otherwise.
  always_ff @(posedge clk) begin
    if (rst || abort || state != ST_EMIT) begin
      sel_q <= SEL_X;
    end else if (out_ready) begin
      sel_q <= (sel_q == SEL_Z) ? SEL_X : sel_q + 2'd1;
    end
  end

  // Flags the first EMIT cycle, when the core's new state is first visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_pending <= 1'b0;
    end else begin
      snap_pending <= (state_nxt == ST_EMIT) && (state != ST_EMIT);
    end
  end

  // Capture x/y/z on that first EMIT cycle so later beats are self-contained.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_x <= '0;
      snap_y <= '0;
      snap_z <= '0;
    end else if (state == ST_EMIT && snap_pending) begin
      snap_x <= x;
      snap_y <= y;
      snap_z <= z;
    end
  end

  // Sample word mux: live core value on the first EMIT cycle, snapshot after.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (sel_q)
        SEL_X:   out_data = snap_pending ? x : snap_x;
        SEL_Y:   out_data = snap_pending ? y : snap_y;
        default: out_data = snap_pending ? z : snap_z;
      endcase
    end
  end

  assign out_sel = sel_q;

endmodule

// File: tb/tb_dda_run_ctrl.sv
// tb/tb_dda_run_ctrl.sv - self-checking bench for dda_run_ctrl with a stand-in DDA core
module tb_dda_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, dda_en, dda_rst, out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] icx, icy, icz, sigma, beta, rho, dt, out_data;
  logic [15:0] x, y, z;
  logic [1:0]  out_sel;

  always #5 clk = ~clk;

  dda_run_ctrl #(.N(16), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .icx(icx), .icy(icy), .icz(icz), .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .dda_en(dda_en), .dda_rst(dda_rst), .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  // Stand-in integrator: any deterministic state update serves to trace steps.
  function automatic logic [47:0] core_step(input logic [47:0] s, input logic [15:0] p_sigma,
                                            input logic [15:0] p_beta, input logic [15:0] p_rho,
                                            input logic [15:0] p_dt);
    logic [15:0] sx, sy, sz;
    {sx, sy, sz} = s;
    return {16'(sx + (sy ^ p_sigma) + p_dt), 16'(sy + (sx >> 1) + p_rho), 16'(sz ^ (sx + sy) ^ p_beta)};
  endfunction

  logic [15:0] cx = '0, cy = '0, cz = '0;
  always @(posedge clk) begin
    if (dda_en) begin
      if (dda_rst) begin
        cx <= icx; cy <= icy; cz <= icz;
      end else begin
        {cx, cy, cz} <= core_step({cx, cy, cz}, sigma, beta, rho, dt);
      end
    end
  end
  assign x = cx;
  assign y = cy;
  assign z = cz;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] cfg_model [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_word(input int i);
    case (i)
      0: return icx;
      1: return icy;
      2: return icz;
      3: return sigma;
      4: return beta;
      5: return rho;
      default: return dt;
    endcase
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (a[0]) cfg_model[a[3:1]][15:8] = d;
    else      cfg_model[a[3:1]][7:0]  = d;
  endtask

  task automatic set_word(input int i, input logic [15:0] v);
    cfg_write(4'(2 * i), v[7:0]);
    cfg_write(4'(2 * i + 1), v[15:8]);
  endtask

  task automatic check_cfg(input string tag);
    for (int i = 0; i < 7; i++) chk($sformatf("%s_w%0d", tag, i), dut_word(i), cfg_model[i]);
  endtask

  logic [15:0] got_data [$];
  logic [1:0]  got_sel [$];
  int n_load, n_step, n_stall, done_cyc, hold_bad;

  // mode 0: always ready, 1: random ready, 2: stall stall_len cycles on the y beat.
  task automatic run_and_watch(input int mode, input int stall_len, input bit poke, input int max_cyc);
    int cyc, stall_left;
    bit pv, finished;
    logic [15:0] pd;
    logic [1:0] ps;
    got_data.delete(); got_sel.delete();
    n_load = 0; n_step = 0; n_stall = 0; done_cyc = -1; hold_bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; stall_left = stall_len; pv = 0; finished = 0; pd = '0; ps = '0;
    while (!finished && cyc < max_cyc) begin
      if (pv && (out_data !== pd || out_sel !== ps || dda_en !== 1'b0)) hold_bad++;
      if (dda_en && dda_rst) n_load++;
      if (dda_en && !dda_rst) n_step++;
      if (done) begin done_cyc = cyc; finished = 1; end
      if (poke && cyc == 3) begin
        cfg_we = 1'b1; cfg_addr = 4'h0; cfg_data = 8'hAA; start = 1'b1;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && out_sel == 2'd1 && stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      pv = out_valid && !out_ready; pd = out_data; ps = out_sel;
      if (pv) n_stall++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data); got_sel.push_back(out_sel);
      end
      @(negedge clk);
      cyc++;
    end
    cfg_we = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk("run_finished", 32'(finished), 32'd1);
  endtask

  // Expected stream: steps+1 samples, sample k is the IC advanced k times.
  task automatic check_run(input string tag, input int steps);
    logic [47:0] s;
    logic [15:0] ev;
    int idx;
    chk({tag, "_loads"}, n_load, 1);
    chk({tag, "_steps"}, n_step, steps);
    chk({tag, "_nbeats"}, got_data.size(), 3 * (steps + 1));
    chk({tag, "_done_cyc"}, done_cyc, 5 + 4 * steps + n_stall);
    chk({tag, "_hold"}, hold_bad, 0);
    s = {cfg_model[0], cfg_model[1], cfg_model[2]};
    for (int k = 0; k <= steps; k++) begin
      for (int j = 0; j < 3; j++) begin
        idx = 3 * k + j;
        ev = (j == 0) ? s[47:32] : (j == 1) ? s[31:16] : s[15:0];
        if (idx < got_data.size()) begin
          chk($sformatf("%s_data%0d", tag, idx), got_data[idx], ev);
          chk($sformatf("%s_sel%0d", tag, idx), got_sel[idx], j);
        end
      end
      s = core_step(s, cfg_model[3], cfg_model[4], cfg_model[5], cfg_model[6]);
    end
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    int          word;
    logic [15:0] exp;
  } cfg_vec_t;

  cfg_vec_t vecs [10];

  initial begin
    bit ab, saw_done;
    int steps_r;

    for (int i = 0; i < 8; i++) cfg_model[i] = '0;
    vecs[0] = '{4'h6, 8'h00, 3, 16'h0000};
    vecs[1] = '{4'h7, 8'h50, 3, 16'h5000};
    vecs[2] = '{4'hE, 8'h03, 7, 16'h0003};
    vecs[3] = '{4'hF, 8'h00, 7, 16'h0003};
    vecs[4] = '{4'h0, 8'h34, 0, 16'h0034};
    vecs[5] = '{4'h1, 8'h12, 0, 16'h1234};
    vecs[6] = '{4'hA, 8'hCD, 5, 16'h00CD};
    vecs[7] = '{4'hB, 8'hAB, 5, 16'hABCD};
    vecs[8] = '{4'h9, 8'hFF, 4, 16'hFF00};
    vecs[9] = '{4'hD, 8'h7E, 6, 16'h7E00};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dda_en", dda_en, 0);
    chk("rst_dda_rst", dda_rst, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    rst = 1'b0;
    check_cfg("rst_cfg");

    // Byte writes: after the first four only sigma (and steps) are non-zero.
    for (int i = 0; i < 10; i++) begin
      cfg_write(vecs[i].addr, vecs[i].data);
      if (vecs[i].word < 7) chk($sformatf("vec%0d", i), dut_word(vecs[i].word), vecs[i].exp);
      if (i == 3) check_cfg("t1");
    end
    check_cfg("vec_all");

    // Abort together with start in IDLE: stays idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // Single-sample run.
    set_word(0, 16'h4000); set_word(1, 16'h4800); set_word(2, 16'h3000); set_word(7, 16'h0000);
    run_and_watch(0, 0, 0, 50);
    check_run("t2", 0);
    chk("t2_done_at5", done_cyc, 5);
    chk("t2_x", got_data.size() > 0 ? got_data[0] : 16'hDEAD, 16'h4000);
    chk("t2_busy_after", busy, 0);

    // Three steps with always-ready consumer.
    set_word(7, 16'd3);
    run_and_watch(0, 0, 0, 60);
    check_run("t3", 3);
    chk("t3_done_at17", done_cyc, 17);

    // Back-pressure on the y beat for 10 cycles.
    set_word(7, 16'd2);
    run_and_watch(2, 10, 0, 80);
    check_run("t4", 2);
    chk("t4_stalls", n_stall, 10);
    chk("t4_done_at23", done_cyc, 23);

    // Abort during the second EMIT.
    set_word(7, 16'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ab = 0; n_step = 0;
    for (int c = 0; c < 40 && !ab; c++) begin
      if (dda_en && !dda_rst) n_step++;
      if (n_step == 1 && out_valid) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ab = 1;
      end else begin
        @(negedge clk);
      end
    end
    chk("t5_abort_reached", 32'(ab), 1);
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_dda_en", dda_en, 0);
    saw_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    chk("t5_no_done", 32'(saw_done), 0);
    cfg_write(4'hC, 8'h77);
    chk("t5_dt_lo", dt[7:0], 8'h77);

    // Writes and start while busy are ignored.
    set_word(7, 16'd2);
    run_and_watch(0, 0, 1, 60);
    check_run("t6", 2);
    chk("t6_icx_kept", icx, cfg_model[0]);
    chk("t6_busy_after", busy, 0);
    @(negedge clk);
    chk("t6_no_restart", busy, 0);

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 7; i++) set_word(i, 16'($urandom));
      steps_r = $urandom_range(0, 5);
      set_word(7, 16'(steps_r));
      check_cfg($sformatf("rnd%0d_cfg", r));
      run_and_watch(1, 0, 0, 300);
      check_run($sformatf("rnd%0d", r), steps_r);
    end

    // Reset in the middle of a run clears everything.
    set_word(7, 16'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) cfg_model[i] = '0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_dda_en", dda_en, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_sel", out_sel, 0);
    check_cfg("t6_rst_cfg");
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
